// File: rtl/ecc_pkg.sv
// Shared constants and types for the ECC host controller slice.
package ecc_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned OPND_W    = 163;
    localparam int unsigned BUS_W     = 176;
    localparam int unsigned NUM_WORDS = 11;
    localparam int unsigned RES_WORDS = 22;

    localparam int unsigned G_BASE    = 0;
    localparam int unsigned K_BASE    = 11;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        SEND = 2'd3
    } state_e;

endpackage

// File: rtl/ecc_host_ctrl_if.sv
// Host, core and result-stream signals of the ECC host controller.
interface ecc_host_ctrl_if;
    import ecc_pkg::*;

    logic                    cfg_we;
    logic [ADDR_W-1:0]       cfg_addr;
    logic [WORD_W-1:0]       cfg_wdata;
    logic                    cmd_start;
    logic                    busy;
    logic                    err_timeout;

    logic                    ecc_start;
    logic [OPND_W-1:0]       ecc_g;
    logic [OPND_W-1:0]       ecc_k;
    logic [BUS_W-1:0]        ecc_outxa;
    logic [BUS_W-1:0]        ecc_outza;
    logic                    ecc_done;

    logic                    res_valid;
    logic [WORD_W-1:0]       res_data;
    logic                    res_last;
    logic                    res_ready;

    // Controller side
    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cmd_start,
        input  ecc_outxa, ecc_outza, ecc_done,
        input  res_ready,
        output busy, err_timeout,
        output ecc_start, ecc_g, ecc_k,
        output res_valid, res_data, res_last
    );

    // Host and core side
    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cmd_start,
        output ecc_outxa, ecc_outza, ecc_done,
        output res_ready,
        input  busy, err_timeout,
        input  ecc_start, ecc_g, ecc_k,
        input  res_valid, res_data, res_last
    );

endinterface

// File: rtl/ecc_word_serializer.sv
// Streams a 352-bit result ({za, xa}) as 22 16-bit words over valid/ready.
// The parallel input must stay stable from load until the last word is taken.
module ecc_word_serializer
    import ecc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [2*BUS_W-1:0]    par_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [WORD_W-1:0]     data_o,
    output logic                  last_o,
    output logic                  done_c
);

    localparam int unsigned SH_W = 9;

    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               valid_q, valid_d;
    logic [WORD_W-1:0]  data_q,  data_d;
    logic               last_q,  last_d;
    logic               accept_c;
    logic [2*BUS_W-1:0] shifted_c;

    // Next word selection and index advance
    always_comb begin
        idx_d     = idx_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        accept_c  = valid_q & ready_i;
        done_c    = accept_c & last_q;
        shifted_c = par_i >> (SH_W'(WORD_W) * SH_W'(idx_q + IDX_W'(1)));

        if (load_i) begin
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = par_i[WORD_W-1:0];
            last_d  = 1'b0;
        end else if (accept_c) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
                data_d = shifted_c[WORD_W-1:0];
                last_d = (idx_q + IDX_W'(1)) == IDX_W'(RES_WORDS - 1);
            end
        end
    end

    // Output and index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/ecc_host_ctrl.sv
// Initiator-side controller for the ECC point-multiply core: operand load,
// start/done handshake with timeout, result capture and word streaming.
module ecc_host_ctrl
    import ecc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TO_W        = 13
) (
    input  logic             clk,
    input  logic             rst,
    ecc_host_ctrl_if.slave   bus
);

    localparam int unsigned SH_W = 8;

    state_e             state_q, state_d;
    logic               busy_q,  busy_d;
    logic               err_q,   err_d;
    logic               start_q, start_d;
    logic [TO_W-1:0]    cnt_q,   cnt_d;
    logic [BUS_W-1:0]   g_q,  g_d;
    logic [BUS_W-1:0]   k_q,  k_d;
    logic [BUS_W-1:0]   xa_q, xa_d;
    logic [BUS_W-1:0]   za_q, za_d;

    logic               ser_load_c;
    logic               ser_done_c;
    logic               wr_g_c;
    logic [ADDR_W-1:0]  widx_c;
    logic [BUS_W-1:0]   wmask_c;
    logic [BUS_W-1:0]   wdata_c;

    // Operand writes and FSM next state
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        err_d      = err_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        g_d        = g_q;
        k_d        = k_q;
        xa_d       = xa_q;
        za_d       = za_q;
        ser_load_c = 1'b0;

        wr_g_c  = bus.cfg_addr < ADDR_W'(K_BASE);
        widx_c  = wr_g_c ? (bus.cfg_addr - ADDR_W'(G_BASE))
                         : (bus.cfg_addr - ADDR_W'(K_BASE));
        wmask_c = BUS_W'({WORD_W{1'b1}}) << (SH_W'(WORD_W) * SH_W'(widx_c));
        wdata_c = BUS_W'(bus.cfg_wdata)  << (SH_W'(WORD_W) * SH_W'(widx_c));

        if (bus.cfg_we && !busy_q && (bus.cfg_addr < ADDR_W'(RES_WORDS))) begin
            if (wr_g_c) begin
                g_d = (g_q & ~wmask_c) | wdata_c;
            end else begin
                k_d = (k_q & ~wmask_c) | wdata_c;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_start) begin
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + TO_W'(1);
                if (bus.ecc_done) begin
                    xa_d    = bus.ecc_outxa;
                    za_d    = bus.ecc_outza;
                    start_d = 1'b0;
                    state_d = REL;
                end else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            REL: begin
                // A done still high from this command must not start the stream
                if (!bus.ecc_done) begin
                    ser_load_c = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (ser_done_c) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= '0;
            g_q     <= '0;
            k_q     <= '0;
            xa_q    <= '0;
            za_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            k_q     <= k_d;
            xa_q    <= xa_d;
            za_q    <= za_d;
        end
    end

    ecc_word_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load_c),
        .par_i   ({za_q, xa_q}),
        .ready_i (bus.res_ready),
        .valid_o (bus.res_valid),
        .data_o  (bus.res_data),
        .last_o  (bus.res_last),
        .done_c  (ser_done_c)
    );

    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;
    assign bus.ecc_start   = start_q;
    assign bus.ecc_g       = g_q[OPND_W-1:0];
    assign bus.ecc_k       = k_q[OPND_W-1:0];

endmodule

// File: tb/tb_ecc_host_ctrl.sv
// Directed-vector bench for ecc_host_ctrl with a small ECC core model.
module tb_ecc_host_ctrl;
    import ecc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic core_en;
    int   core_cnt;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] exp_w [22];

    always #5 clk = ~clk;

    ecc_host_ctrl_if bus ();

    ecc_host_ctrl #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Core model: raises done three cycles into a request, drops it once start falls
    always @(negedge clk) begin
        if (rst || !bus.ecc_start) begin
            core_cnt     = 0;
            bus.ecc_done = 1'b0;
        end else if (core_en && !bus.ecc_done) begin
            core_cnt = core_cnt + 1;
            if (core_cnt == 3) bus.ecc_done = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [4:0] a, input logic [15:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    // mode 0: ready always; 1: ready pattern 1-0-0-1; 2: ready always plus
    // a write and a second cmd_start during SEND. abort_at >= 0 resets at that word.
    task automatic run_stream(input int mode, input int abort_at);
        int          idx;
        int          cyc;
        logic        seen_done;
        logic        prev_start;
        logic        stalled;
        logic        aborted;
        logic [15:0] hold;
        idx = 0; cyc = 0; seen_done = 0; prev_start = 0;
        stalled = 0; aborted = 0; hold = '0;
        bus.res_ready = 1'b0;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        chk("busy_on",  32'(bus.busy), 32'd1);
        chk("start_on", 32'(bus.ecc_start), 32'd1);
        chk("err_clr",  32'(bus.err_timeout), 32'd0);
        while (idx < 22 && cyc < 300 && !aborted) begin
            if (bus.ecc_done && !seen_done) begin
                seen_done = 1;
                chk("start_drop", 32'(bus.ecc_start), 32'd0);
                chk("start_prev", 32'(prev_start), 32'd1);
            end
            prev_start = bus.ecc_start;
            if (stalled) begin
                chk("stall_valid", 32'(bus.res_valid), 32'd1);
                chk("stall_hold",  32'(bus.res_data), 32'(hold));
            end
            if (mode == 1) bus.res_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else           bus.res_ready = 1'b1;
            if (mode == 2 && idx == 1 && bus.res_valid) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 5'd3;
                bus.cfg_wdata = 16'hAAAA;
                bus.cmd_start = 1'b1;
            end
            if (abort_at >= 0 && idx == abort_at && bus.res_valid) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_start", 32'(bus.ecc_start), 32'd0);
                chk("rst_valid", 32'(bus.res_valid), 32'd0);
                chk("rst_busy",  32'(bus.busy), 32'd0);
                chk("rst_g",     32'(bus.ecc_g == '0), 32'd1);
                aborted = 1;
            end else begin
                stalled = bus.res_valid && !bus.res_ready;
                hold    = bus.res_data;
                if (bus.res_valid && bus.res_ready) begin
                    chk($sformatf("word%0d", idx), 32'(bus.res_data), 32'(exp_w[idx]));
                    chk($sformatf("last%0d", idx), 32'(bus.res_last), 32'(idx == 21));
                    idx++;
                end
                tick();
                bus.cfg_we    = 1'b0;
                bus.cmd_start = 1'b0;
                cyc++;
            end
        end
        bus.res_ready = 1'b0;
        if (!aborted) begin
            chk("word_count", 32'(idx), 32'd22);
            chk("busy_off",   32'(bus.busy), 32'd0);
            chk("valid_off",  32'(bus.res_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   start_cnt;
        logic saw_valid;
        for (int i = 0; i < 22; i++) exp_w[i] = 16'h0000;
        exp_w[0]  = 16'hC3D4;
        exp_w[1]  = 16'hA1B2;
        exp_w[11] = 16'h0789;
        exp_w[12] = 16'hE5F6;

        rst           = 1'b1;
        core_en       = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.cmd_start = 1'b0;
        bus.res_ready = 1'b0;
        bus.ecc_outxa = 176'hA1B2C3D4;
        bus.ecc_outza = 176'hE5F60789;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_err",   32'(bus.err_timeout), 32'd0);
        chk("rst_start", 32'(bus.ecc_start), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_g",     32'(bus.ecc_g == '0), 32'd1);

        // Operand load, top bits beyond 163 not forwarded
        cfg_wr(5'd0,  16'h1234);
        cfg_wr(5'd10, 16'hFFFF);
        cfg_wr(5'd11, 16'hBEEF);
        cfg_wr(5'd25, 16'h5555);
        chk("g_w0",  32'(bus.ecc_g[15:0]), 32'h1234);
        chk("g_top", 32'(bus.ecc_g[162:160]), 32'h7);
        chk("k_w0",  32'(bus.ecc_k[15:0]), 32'hBEEF);
        chk("g_w1",  32'(bus.ecc_g[31:16]), 32'h0);

        // Full stream, ready held high
        run_stream(0, -1);
        // Stream with back-pressure
        run_stream(1, -1);

        // Timeout: core never answers
        core_en   = 1'b0;
        start_cnt = 0;
        saw_valid = 1'b0;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ecc_start) start_cnt++;
            if (bus.res_valid) saw_valid = 1'b1;
            tick();
        end
        chk("to_start_cyc", 32'(start_cnt), 32'd16);
        chk("to_no_valid",  32'(saw_valid), 32'd0);
        chk("to_err",       32'(bus.err_timeout), 32'd1);
        chk("to_busy",      32'(bus.busy), 32'd0);
        core_en = 1'b1;
        run_stream(0, -1);

        // Write and cmd_start while busy are ignored
        run_stream(2, -1);
        chk("g_w3_kept", 32'(bus.ecc_g[63:48]), 32'h0);
        tick();
        chk("no_restart", 32'(bus.busy), 32'd0);

        // Reset during REQ
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("req_rst_start", 32'(bus.ecc_start), 32'd0);
        chk("req_rst_busy",  32'(bus.busy), 32'd0);
        chk("req_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("req_rst_g",     32'(bus.ecc_g == '0), 32'd1);
        tick();

        // Reset during SEND at word 5, then a clean command
        cfg_wr(5'd0, 16'h1234);
        run_stream(0, 5);
        tick();
        run_stream(0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
